// File: rtl/muldiv_if.sv
// Request/response bundle between a pipeline issue stage and the
// iterative multiply/divide unit. The issuer is the master; the unit is the slave.
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        write_ctrl;
  logic [4:0]  write_addr;

  modport master (
    output start, funct3, rs1, rs2, rd_addr,
    input  busy, done, result, write_ctrl, write_addr
  );

  modport slave (
    input  start, funct3, rs1, rs2, rd_addr,
    output busy, done, result, write_ctrl, write_addr
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One radix-2 step per cycle: shift-add multiply or restoring divide on
// operand magnitudes, 32 steps for every op, then a sign fix-up when the
// result is registered. Latency is fixed regardless of op or operands.
module muldiv_unit (
  input  logic      clk,
  input  logic      rst,
  muldiv_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;

  // Operation context captured on the accept edge.
  logic [2:0]  op_reg;
  logic [4:0]  rd_reg;
  logic [31:0] a_raw_reg;     // original rs1, needed for REM/REMU by zero
  logic        div_zero_reg;
  logic        q_neg_reg;     // negate product / quotient
  logic        r_neg_reg;     // negate remainder (follows dividend)

  // Iteration registers, shared by multiply and divide:
  //   multiply: acc_hi = running high half, acc_lo = multiplier shifting out
  //             / product low bits shifting in, opb = multiplicand magnitude
  //   divide:   acc_hi = partial remainder, acc_lo = dividend shifting out
  //             / quotient bits shifting in, opb = divisor magnitude
  logic [31:0] acc_hi_reg;
  logic [31:0] acc_lo_reg;
  logic [31:0] opb_reg;

  logic [31:0] result_reg;
  logic [4:0]  write_addr_reg;

  logic        accept;
  logic        last_step;

  // Operand decode for the accept edge.
  logic        in_is_div;
  logic        in_a_signed;
  logic        in_b_signed;
  logic        in_sa;
  logic        in_sb;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;

  // Single iteration step.
  logic        is_div;
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_next;
  logic [31:0] mul_lo_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_hi_next;
  logic [31:0] div_lo_next;
  logic [31:0] acc_hi_next;
  logic [31:0] acc_lo_next;

  // Final result formation.
  logic [63:0] product;
  logic [63:0] product_fixed;
  logic [31:0] mul_res;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] div_res;
  logic [31:0] final_res;

  // Output drivers.
  logic        busy_out;
  logic        done_out;
  logic        write_ctrl_out;

  assign accept    = (state_reg == IDLE) && bus.start;
  assign last_step = (state_reg == CALC) && (count_reg == 5'd31);

  // Decode signedness and take operand magnitudes for the incoming request.
  always_comb begin
    in_is_div   = bus.funct3[2];
    in_a_signed = 1'b0;
    in_b_signed = 1'b0;
    if (in_is_div) begin
      // DIV and REM are signed; DIVU and REMU are not.
      in_a_signed = ~bus.funct3[0];
      in_b_signed = ~bus.funct3[0];
    end else begin
      // MUL keeps both unsigned: its low word is sign-agnostic.
      in_a_signed = (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
      in_b_signed = (bus.funct3[1:0] == 2'b01);
    end
    in_sa    = in_a_signed & bus.rs1[31];
    in_sb    = in_b_signed & bus.rs2[31];
    in_a_mag = in_sa ? (32'd0 - bus.rs1) : bus.rs1;
    in_b_mag = in_sb ? (32'd0 - bus.rs2) : bus.rs2;
  end

  // One radix-2 step of either algorithm from the current iteration state.
  always_comb begin
    is_div = op_reg[2];

    // Shift-add: conditionally add the multiplicand, then shift {hi,lo} right.
    mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : 33'd0);
    mul_hi_next = mul_sum[32:1];
    mul_lo_next = {mul_sum[0], acc_lo_reg[31:1]};

    // Restoring: shift in the next dividend bit and subtract if it fits.
    // The true difference is below the divisor, so 32-bit wraparound is exact.
    div_shift   = {acc_hi_reg, acc_lo_reg[31]};
    div_ge      = (div_shift >= {1'b0, opb_reg});
    div_hi_next = div_ge ? (div_shift[31:0] - opb_reg) : div_shift[31:0];
    div_lo_next = {acc_lo_reg[30:0], div_ge};

    acc_hi_next = is_div ? div_hi_next : mul_hi_next;
    acc_lo_next = is_div ? div_lo_next : mul_lo_next;
  end

  // Apply sign rules and special cases to the post-final-step values.
  always_comb begin
    product       = {acc_hi_next, acc_lo_next};
    product_fixed = q_neg_reg ? (64'd0 - product) : product;
    mul_res       = (op_reg[1:0] == 2'b00) ? product_fixed[31:0] : product_fixed[63:32];

    // Signed overflow (0x80000000 / -1) falls out naturally: magnitude
    // quotient 0x80000000 negates to itself and the remainder is 0.
    quo_fixed = q_neg_reg ? (32'd0 - acc_lo_next) : acc_lo_next;
    rem_fixed = r_neg_reg ? (32'd0 - acc_hi_next) : acc_hi_next;

    if (div_zero_reg) begin
      div_res = op_reg[1] ? a_raw_reg : 32'hFFFF_FFFF;
    end else begin
      div_res = op_reg[1] ? rem_fixed : quo_fixed;
    end

    final_res = is_div ? div_res : mul_res;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state and status outputs.
  always_comb begin
    state_next     = state_reg;
    busy_out       = 1'b0;
    done_out       = 1'b0;
    write_ctrl_out = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        busy_out = 1'b1;
        if (count_reg == 5'd31) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_out       = 1'b1;
        done_out       = 1'b1;
        write_ctrl_out = (write_addr_reg != 5'd0);
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, register result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg      <= 5'd0;
      op_reg         <= 3'd0;
      rd_reg         <= 5'd0;
      a_raw_reg      <= 32'd0;
      div_zero_reg   <= 1'b0;
      q_neg_reg      <= 1'b0;
      r_neg_reg      <= 1'b0;
      acc_hi_reg     <= 32'd0;
      acc_lo_reg     <= 32'd0;
      opb_reg        <= 32'd0;
      result_reg     <= 32'd0;
      write_addr_reg <= 5'd0;
    end else if (accept) begin
      count_reg    <= 5'd0;
      op_reg       <= bus.funct3;
      rd_reg       <= bus.rd_addr;
      a_raw_reg    <= bus.rs1;
      div_zero_reg <= (bus.rs2 == 32'd0);
      q_neg_reg    <= in_sa ^ in_sb;
      r_neg_reg    <= in_sa;
      acc_hi_reg   <= 32'd0;
      acc_lo_reg   <= in_is_div ? in_a_mag : in_b_mag;
      opb_reg      <= in_is_div ? in_b_mag : in_a_mag;
    end else if (state_reg == CALC) begin
      count_reg  <= count_reg + 5'd1;
      acc_hi_reg <= acc_hi_next;
      acc_lo_reg <= acc_lo_next;
      if (last_step) begin
        result_reg     <= final_res;
        write_addr_reg <= rd_reg;
      end
    end
  end

  assign bus.busy       = busy_out;
  assign bus.done       = done_out;
  assign bus.write_ctrl = write_ctrl_out;
  assign bus.result     = result_reg;
  assign bus.write_addr = write_addr_reg;

endmodule
